// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the calendar stages of the century clock.
//   month_len_e  : length code for the current month (28/29/30/31 days)
//   MONTH_MIN/MAX: legal month range, 01..12
//   month_bin()  : BCD tens/units pair to binary month number
package clock_pkg;

  typedef enum logic [1:0] {
    LEN_28 = 2'd0,
    LEN_29 = 2'd1,
    LEN_30 = 2'd2,
    LEN_31 = 2'd3
  } month_len_e;

  localparam int MONTH_MIN = 1;
  localparam int MONTH_MAX = 12;

  // Callers zero-extend their display fields to 4 bits before calling.
  function automatic logic [7:0] month_bin(input logic [3:0] ten, input logic [3:0] unit);
    return 8'(ten) * 8'd10 + 8'(unit);
  endfunction

endpackage

// File: rtl/month_len_decode.sv
// month_len_decode: combinational month -> length code.
// Ports:
//   month_ten  (in)  BCD tens of the month
//   month_unit (in)  BCD units of the month
//   leap       (in)  current year is a leap year
//   len        (out) month length code
// Macro LEAP_YEAR_EN: when defined, leap picks 29 days for February;
// when undefined, leap is ignored and February is always 28 days.
module month_len_decode
  import clock_pkg::*;
#(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 1
) (
  input  logic [MAX_DISPLAY_TEN-1:0]  month_ten,
  input  logic [MAX_DISPLAY_UNIT-1:0] month_unit,
  input  logic                        leap,
  output month_len_e                  len
);

  logic leap_eff;

`ifdef LEAP_YEAR_EN
  assign leap_eff = leap;
`else
  // The port stays so the interface is identical in both builds.
  assign leap_eff = 1'b0 & leap;
`endif

  always_comb begin
    len = LEN_31;
    case (month_bin(4'(month_ten), 4'(month_unit)))
      8'd4, 8'd6, 8'd9, 8'd11: len = LEN_30;
      8'd2:                    len = leap_eff ? LEN_29 : LEN_28;
      default:                 len = LEN_31;
    endcase
  end

endmodule

// File: rtl/count_month.sv
// count_month: BCD month counter 01..12 of the century clock.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en_d               day-advance strobe (shared with the day counter)
//   day_31..day_28     day counter flags for the current day
//   leap               current year is a leap year
//   sel_m, up, down    manual month adjust
//   month_unit/ten     BCD month
//   preset_d           forces the day counter to 01
//   en_y               one-cycle carry to the year stage
// Strobe semantics: en_d is a single-cycle strobe with no back-pressure;
// preset_d and en_y are combinational from en_d and valid in the same
// cycle, so month, day and year all update on the same clock edge.
// Macro LEAP_YEAR_EN: enables the leap-year February length.
module count_month
  import clock_pkg::*;
#(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_d,
  input  logic                        day_31,
  input  logic                        day_30,
  input  logic                        day_29,
  input  logic                        day_28,
  input  logic                        leap,
  input  logic                        sel_m,
  input  logic                        up,
  input  logic                        down,
  output logic [MAX_DISPLAY_UNIT-1:0] month_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  month_ten,
  output logic                        preset_d,
  output logic                        en_y
);

  logic [MAX_DISPLAY_UNIT-1:0] unit_q, unit_d, inc_unit, dec_unit;
  logic [MAX_DISPLAY_TEN-1:0]  ten_q, ten_d, inc_ten, dec_ten;
  logic                        clamp_q, clamp_d;
  month_len_e                  len;
  logic                        month_end, overrun, is_dec;

  month_len_decode #(
    .MAX_DISPLAY_UNIT(MAX_DISPLAY_UNIT),
    .MAX_DISPLAY_TEN (MAX_DISPLAY_TEN)
  ) u_len (
    .month_ten (ten_q),
    .month_unit(unit_q),
    .leap      (leap),
    .len       (len)
  );

  always_comb begin
    month_end = 1'b0;
    overrun   = 1'b0;
    case (len)
      LEN_28: begin
        month_end = day_28;
        overrun   = day_29 | day_30 | day_31;
      end
      LEN_29: begin
        month_end = day_29;
        overrun   = day_30 | day_31;
      end
      LEN_30: begin
        month_end = day_30;
        overrun   = day_31;
      end
      default: begin
        month_end = day_31;
        overrun   = 1'b0;
      end
    endcase
  end

  assign is_dec = (month_bin(4'(ten_q), 4'(unit_q)) == 8'(MONTH_MAX));

  // BCD successor / predecessor with 12 <-> 01 wrap.
  always_comb begin
    inc_unit = unit_q + MAX_DISPLAY_UNIT'(1);
    inc_ten  = ten_q;
    if (is_dec) begin
      inc_unit = MAX_DISPLAY_UNIT'(MONTH_MIN);
      inc_ten  = '0;
    end else if (unit_q == MAX_DISPLAY_UNIT'(9)) begin
      inc_unit = '0;
      inc_ten  = MAX_DISPLAY_TEN'(1);
    end

    dec_unit = unit_q - MAX_DISPLAY_UNIT'(1);
    dec_ten  = ten_q;
    if (month_bin(4'(ten_q), 4'(unit_q)) == 8'(MONTH_MIN)) begin
      dec_unit = MAX_DISPLAY_UNIT'(2);
      dec_ten  = MAX_DISPLAY_TEN'(1);
    end else if (unit_q == '0) begin
      dec_unit = MAX_DISPLAY_UNIT'(9);
      dec_ten  = '0;
    end
  end

  // en_d owns the cycle: even on a non-last day it blocks manual adjust.
  always_comb begin
    unit_d = unit_q;
    ten_d  = ten_q;
    if (en_d) begin
      if (month_end) begin
        unit_d = inc_unit;
        ten_d  = inc_ten;
      end
    end else if (sel_m & up & ~down) begin
      unit_d = inc_unit;
      ten_d  = inc_ten;
    end else if (sel_m & down & ~up) begin
      unit_d = dec_unit;
      ten_d  = dec_ten;
    end
    // One-cycle pulse; the next evaluation sees the day already at 01.
    clamp_d = overrun & ~clamp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_q  <= MAX_DISPLAY_UNIT'(MONTH_MIN);
      ten_q   <= '0;
      clamp_q <= 1'b0;
    end else begin
      unit_q  <= unit_d;
      ten_q   <= ten_d;
      clamp_q <= clamp_d;
    end
  end

  assign month_unit = unit_q;
  assign month_ten  = ten_q;
  assign preset_d   = (en_d & month_end) | clamp_q;
  assign en_y       = en_d & month_end & is_dec;

endmodule

// File: tb/tb_count_month.sv
module tb_count_month;

  logic       clk = 1'b0;
  logic       rst, en_d, sel_m, up, down, leap;
  logic       day_31, day_30, day_29, day_28;
  logic [3:0] month_unit;
  logic [0:0] month_ten;
  logic       preset_d, en_y;
  int         day;

  // clock/reset block
  always #5 clk = ~clk;

  // Minimal day counter environment: day flags follow the day value.
  assign day_31 = (day == 31);
  assign day_30 = (day == 30);
  assign day_29 = (day == 29);
  assign day_28 = (day == 28);

  count_month #(
    .MAX_DISPLAY_UNIT(4),
    .MAX_DISPLAY_TEN (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_d      (en_d),
    .day_31    (day_31),
    .day_30    (day_30),
    .day_29    (day_29),
    .day_28    (day_28),
    .leap      (leap),
    .sel_m     (sel_m),
    .up        (up),
    .down      (down),
    .month_unit(month_unit),
    .month_ten (month_ten),
    .preset_d  (preset_d),
    .en_y      (en_y)
  );

  // scoreboard: {ten, unit, preset_d, en_y}
  logic [6:0] exp_q[$];
  string      name_q[$];
  logic       chk_req;
  logic       seen_preset;
  int         checks = 0;
  int         errors = 0;

  // monitor
  always @(negedge clk) begin
    logic [6:0] act, exp_v;
    string      nm;
    seen_preset = preset_d;
    if (chk_req) begin
      act = {month_ten, month_unit, preset_d, en_y};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %0s: no expectation queued, got %b", "scoreboard", act);
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL %0s: got month=%0d%0d preset_d=%b en_y=%b, want month=%0d%0d preset_d=%b en_y=%b",
                   nm, act[6], act[5:2], act[1], act[0], exp_v[6], exp_v[5:2], exp_v[1], exp_v[0]);
        end
      end
      chk_req = 1'b0;
    end
  end

  // driver: one clock cycle with inputs and expected outputs for that cycle
  task automatic cyc(input logic r, input logic e, input logic s, input logic u, input logic d,
                     input int m, input logic p, input logic y, input string nm);
    rst   = r;
    en_d  = e;
    sel_m = s;
    up    = u;
    down  = d;
    exp_q.push_back({(m >= 10) ? 1'b1 : 1'b0, 4'(m % 10), p, y});
    name_q.push_back(nm);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    if (seen_preset === 1'b1) day = 1;
    else if (e) day = day + 1;
  endtask

  logic feb29_clamp;

  initial begin
    rst = 1'b1; en_d = 1'b0; sel_m = 1'b0; up = 1'b0; down = 1'b0; leap = 1'b0;
    day = 1; chk_req = 1'b0; seen_preset = 1'b0;
`ifdef LEAP_YEAR_EN
    feb29_clamp = 1'b0;
`else
    feb29_clamp = 1'b1;
`endif
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0,  1, 0, 0, "reset");
    cyc(0, 0, 0, 0, 0,  1, 0, 0, "post_reset");

    // end of January
    day = 31;
    cyc(0, 1, 0, 0, 0,  1, 1, 0, "jan_end_preset");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "feb_after_jan");

    // reach December manually, then year carry
    cyc(0, 0, 1, 0, 1,  2, 0, 0, "down_from_feb");
    cyc(0, 0, 1, 0, 1,  1, 0, 0, "down_from_jan");
    cyc(0, 0, 0, 0, 0, 12, 0, 0, "wrap_to_dec");
    day = 31;
    cyc(0, 1, 0, 0, 0, 12, 1, 1, "dec_end_carry");
    cyc(0, 0, 0, 0, 0,  1, 0, 0, "jan_after_dec");

    // February end
    cyc(0, 0, 1, 1, 0,  1, 0, 0, "up_from_jan");
    leap = 1'b1;
    day  = 28;
`ifdef LEAP_YEAR_EN
    cyc(0, 1, 0, 0, 0,  2, 0, 0, "feb28_leap_hold");
    cyc(0, 1, 0, 0, 0,  2, 1, 0, "feb29_leap_end");
`else
    cyc(0, 1, 0, 0, 0,  2, 1, 0, "feb28_end");
`endif
    cyc(0, 0, 0, 0, 0,  3, 0, 0, "mar_after_feb");
    leap = 1'b0;

    // manual change into a shorter month clamps the day
    day = 31;
    cyc(0, 0, 1, 0, 1,  3, 0, 0, "mar_down");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "overrun_cycle_n");
    cyc(0, 0, 0, 0, 0,  2, 1, 0, "clamp_pulse");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "clamp_done");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "clamp_no_repeat");

    // wrap both ways, up&down hold, en_d blocks manual
    cyc(0, 0, 1, 0, 1,  2, 0, 0, "down_to_jan");
    cyc(0, 0, 1, 0, 1,  1, 0, 0, "down_wrap");
    cyc(0, 0, 1, 1, 0, 12, 0, 0, "up_wrap");
    cyc(0, 0, 1, 1, 1,  1, 0, 0, "up_down_req");
    cyc(0, 0, 0, 0, 0,  1, 0, 0, "up_down_hold");
    cyc(0, 1, 1, 1, 0,  1, 0, 0, "en_with_up");
    cyc(0, 0, 0, 0, 0,  1, 0, 0, "en_blocks_manual");

    // reset while the clamp pulse is active
    cyc(0, 0, 1, 1, 0,  1, 0, 0, "up_to_feb");
    cyc(0, 0, 1, 1, 0,  2, 0, 0, "up_to_mar");
    day = 31;
    cyc(0, 0, 1, 0, 1,  3, 0, 0, "mar_down_2");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "overrun_cycle_n_2");
    cyc(1, 0, 0, 0, 0,  2, 1, 0, "clamp_at_reset");
    cyc(0, 0, 0, 0, 0,  1, 0, 0, "reset_mid_clamp");
    cyc(0, 0, 0, 0, 0,  1, 0, 0, "no_late_preset");

    // day 29 entered in February: overrun unless leap years are enabled
    leap = 1'b1;
    day  = 29;
    cyc(0, 0, 1, 1, 0,  1, 0, 0, "up_day29");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "feb29_cycle_n");
    cyc(0, 0, 0, 0, 0,  2, feb29_clamp, 0, "feb29_clamp");
    cyc(0, 0, 0, 0, 0,  2, 0, 0, "feb29_settled");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %0s: %0d expectations left, want 0", "drain", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_month.md
# count_month

Month stage of the century clock, directly downstream of the day counter. Consumes the day-advance strobe and the day counter's last-day flags, keeps a BCD month 01..12, and drives the day counter's `preset` at end of month. It also issues a carry strobe to the year stage on December rollover and clamps the day back to 01 when a manual month change leaves it out of range.

## Interface
Parameters:
- `MAX_DISPLAY_UNIT`, 4: width of `month_unit`.
- `MAX_DISPLAY_TEN`, 1: width of `month_ten`.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en_d`  in  1  day-advance strobe; the same signal drives the day counter's `en_d`.
- `day_31`, `day_30`, `day_29`, `day_28`  in  1 each  day counter flags: current day is 31, 30, 29 or 28.
- `leap`  in  1  current year is a leap year, from the year stage.
- `sel_m`  in  1  month field selected for manual adjust.
- `up`, `down`  in  1 each  manual adjust requests.
- `month_unit`  out  `MAX_DISPLAY_UNIT`  BCD units.
- `month_ten`  out  `MAX_DISPLAY_TEN`  BCD tens.
- `preset_d`  out  1  to the day counter's `preset`; forces day to 01.
- `en_y`  out  1  one-cycle carry to the year stage.

## Operation
- Length decode from month (02 uses `leap`):
  - 31 days: 01, 03, 05, 07, 08, 10, 12.
  - 30 days: 04, 06, 09, 11.
  - 02: 29 days if `leap`, else 28.
- `month_end`: the day flag matching the current length (`day_31`/`day_30`/`day_29`/`day_28`).
- `overrun`: day exceeds the current length.
  - 30-day month: `day_31`.
  - 02 non-leap: `day_29`, `day_30` or `day_31`.
  - 02 leap: `day_30` or `day_31`.
- Register priority, highest first:
  1. `rst`: month = 01, `clamp_q` = 0.
  2. `en_d & month_end`: month +1; 12 wraps to 01.
  3. `en_d` without `month_end`: month holds.
  4. `sel_m & up & ~down`: month +1; 12 wraps to 01.
  5. `sel_m & down & ~up`: month −1; 01 wraps to 12.
  6. Otherwise hold, including `up & down` together.
- BCD rules:
  - Units 9 → 0 with tens 0 → 1.
  - Units 0 → 9 with tens 1 → 0.
  - Legal values are only 01..12; tens is never above 1.
- `preset_d = (en_d & month_end) | clamp_q`. The day counter gives `preset` priority over `en_d`, so the last day goes straight to 01.
- `en_y = en_d & month_end & (month == 12)`.
- `clamp_q` register:
  - `clamp_q <= overrun & ~clamp_q & ~rst`.
  - Gives a single-cycle `preset_d` pulse, then re-evaluates once the day is 01.

## Timing
- Reset values: `month_unit` = 1, `month_ten` = 0, `clamp_q` = 0, so `preset_d` = 0 and `en_y` = 0. This holds provided `en_d` is low during reset.
- `preset_d` and `en_y` are Mealy outputs, combinational from `en_d`.
  - They are valid in the same cycle as `en_d`.
  - Month, day and year all update on that same edge.
- Clamp latency:
  - Manual change at edge N makes `overrun` visible in cycle N.
  - `clamp_q` is high in cycle N+1.
  - Day reads 01 after edge N+2.
- `en_d` while `clamp_q` is high: `preset_d` is high either way.
  - Month advances only if `month_end` is true.
  - Manual up/down in that cycle is ignored.
- Reset mid-clamp: `clamp_q` clears on the reset edge; no `preset_d` follows.

## Configuration
- `LEAP_YEAR_EN` defined: `leap` selects 28 or 29 days for February as above.
- `LEAP_YEAR_EN` undefined:
  - `leap` is ignored and February is always 28 days.
  - `day_29` in 02 counts as overrun.
  - The port remains present.

## Structure
- Shared package `clock_pkg`:
  - Month-length codes `LEN_28`, `LEN_29`, `LEN_30`, `LEN_31`.
  - Constants `MONTH_MIN` = 1, `MONTH_MAX` = 12.
- One combinational sub-module, `month_len_decode`: (`month_ten`, `month_unit`, `leap`) → length code. It is reused by the year/leap stage.
- `month_end`, `overrun`, the counter and `clamp_q` stay in `count_month`.

## Test plan
- Reset, then day 31, month 01, pulse `en_d` → `preset_d` = 1 that cycle; next cycle month 02, `en_y` = 0.
- Month 12, day 31, `en_d` → `en_y` = 1 and `preset_d` = 1 for one cycle; month 01.
- Month 02, `day_28`, `leap` = 1, `en_d` → month stays 02, `preset_d` = 0. Repeat with `day_29` → month 03, `preset_d` = 1. Without `LEAP_YEAR_EN`, `day_28` alone rolls to 03.
- Month 03, day 31, `sel_m` with `down` one cycle → month 02; `preset_d` = 1 exactly in cycle N+1; no further pulse once day reads 01.
- Month 01, `sel_m` and `down` → 12; then `up` → 01; `up & down` together → hold; `en_d` with `sel_m & up` on a non-last day → month unchanged.
- Assert `rst` while `clamp_q` = 1 → next cycle month 01, `preset_d` = 0, `en_y` = 0.
